// File: rtl/level_sequencer.sv
`default_nettype none
// =============================================================================
// level_sequencer : level, row-speed and row-width controller for block stacking
// Revision: 1.0
// =============================================================================
module level_sequencer #(
    parameter int unsigned NUM_LEVELS   = 15,
    parameter int unsigned LEVEL_W      = 6,
    parameter int unsigned SPEED_W      = 11,
    parameter int unsigned BASE_SPEED   = 60,
    parameter int unsigned SPEED_STEP   = 4,
    parameter int unsigned MIN_SPEED    = 12,
    parameter int unsigned MAX_BLOCKS   = 3,
    parameter int unsigned BLOCK_W      = 4,
    parameter int unsigned SHRINK_EVERY = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               place_valid,
    input  logic [BLOCK_W-1:0] place_blocks,
    output logic [SPEED_W-1:0] speed_count,
    output logic [BLOCK_W-1:0] num_blocks,
    output logic [LEVEL_W-1:0] curr_level,
    output logic [LEVEL_W-1:0] best_level,
    output logic               playing,
    output logic               game_won,
    output logic               game_over
);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WON  = 2'd2;
    localparam logic [1:0] ST_LOST = 2'd3;

    localparam int unsigned SHR_W = (SHRINK_EVERY > 1) ? $clog2(SHRINK_EVERY) : 1;

    localparam logic [LEVEL_W-1:0] LEVEL_ONE   = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(NUM_LEVELS);
    localparam logic [SPEED_W-1:0] SPEED_BASE  = SPEED_W'(BASE_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_MIN   = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_DEC   = SPEED_W'(SPEED_STEP);
    localparam logic [SPEED_W:0]   SPEED_THR   = (SPEED_W + 1)'(MIN_SPEED + SPEED_STEP);
    localparam logic [BLOCK_W-1:0] BLOCK_ONE   = BLOCK_W'(1);
    localparam logic [BLOCK_W-1:0] BLOCK_MAX   = BLOCK_W'(MAX_BLOCKS);
    localparam logic [SHR_W-1:0]   SHRINK_LAST = SHR_W'(SHRINK_EVERY - 1);
    localparam logic [SHR_W-1:0]   SHRINK_ONE  = SHR_W'(1);

    logic [1:0]         state_q,   state_d;
    logic [LEVEL_W-1:0] level_q,   level_d;
    logic [LEVEL_W-1:0] best_q,    best_d;
    logic [SPEED_W-1:0] speed_q,   speed_d;
    logic [BLOCK_W-1:0] blocks_q,  blocks_d;
    logic [BLOCK_W-1:0] cap_q,     cap_d;
    logic [SHR_W-1:0]   shrink_q,  shrink_d;
    logic               playing_q, won_q, over_q;

    // Values a successful (non-final) placement would produce
    logic [BLOCK_W-1:0] eff_w;
    logic [LEVEL_W-1:0] level_inc_w;
    logic [LEVEL_W-1:0] best_adv_w;
    logic [SPEED_W-1:0] speed_adv_w;
    logic               shrink_wrap_w;
    logic [SHR_W-1:0]   shrink_adv_w;
    logic [BLOCK_W-1:0] cap_adv_w;
    logic [BLOCK_W-1:0] blocks_adv_w;

    always_comb begin
        eff_w         = (place_blocks < blocks_q) ? place_blocks : blocks_q;
        level_inc_w   = level_q + LEVEL_ONE;
        best_adv_w    = (best_q > level_inc_w) ? best_q : level_inc_w;
        // Widened compare keeps MIN_SPEED + SPEED_STEP from overflowing SPEED_W
        speed_adv_w   = ({1'b0, speed_q} >= SPEED_THR) ? (speed_q - SPEED_DEC) : SPEED_MIN;
        shrink_wrap_w = (shrink_q == SHRINK_LAST);
        shrink_adv_w  = shrink_wrap_w ? '0 : (shrink_q + SHRINK_ONE);
        if (shrink_wrap_w) begin
            cap_adv_w = (cap_q > BLOCK_ONE) ? (cap_q - BLOCK_ONE) : BLOCK_ONE;
        end else begin
            cap_adv_w = cap_q;
        end
        blocks_adv_w  = (eff_w < cap_adv_w) ? eff_w : cap_adv_w;
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        best_d   = best_q;
        speed_d  = speed_q;
        blocks_d = blocks_q;
        cap_d    = cap_q;
        shrink_d = shrink_q;

        case (state_q)
            ST_WAIT: begin
                if (go) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (place_valid) begin
                    if (eff_w == '0) begin
                        state_d = ST_LOST;
                    end else if (level_q == LEVEL_LAST) begin
                        state_d = ST_WON;
                    end else begin
                        state_d  = ST_WAIT;
                        level_d  = level_inc_w;
                        best_d   = best_adv_w;
                        speed_d  = speed_adv_w;
                        blocks_d = blocks_adv_w;
                        cap_d    = cap_adv_w;
                        shrink_d = shrink_adv_w;
                    end
                end
            end
            ST_WON, ST_LOST: begin
                // Restart lands in WAIT with the high-water level kept
                if (go) begin
                    state_d  = ST_WAIT;
                    level_d  = LEVEL_ONE;
                    speed_d  = SPEED_BASE;
                    blocks_d = BLOCK_MAX;
                    cap_d    = BLOCK_MAX;
                    shrink_d = '0;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_WAIT;
            level_q   <= LEVEL_ONE;
            best_q    <= LEVEL_ONE;
            speed_q   <= SPEED_BASE;
            blocks_q  <= BLOCK_MAX;
            cap_q     <= BLOCK_MAX;
            shrink_q  <= '0;
            playing_q <= 1'b0;
            won_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            best_q    <= best_d;
            speed_q   <= speed_d;
            blocks_q  <= blocks_d;
            cap_q     <= cap_d;
            shrink_q  <= shrink_d;
            playing_q <= (state_d == ST_PLAY);
            won_q     <= (state_d == ST_WON);
            over_q    <= (state_d == ST_LOST);
        end
    end

    assign speed_count = speed_q;
    assign num_blocks  = blocks_q;
    assign curr_level  = level_q;
    assign best_level  = best_q;
    assign playing     = playing_q;
    assign game_won    = won_q;
    assign game_over   = over_q;

endmodule
`default_nettype wire
